// File: rtl/blit_outer_seq.sv
// blit_outer_seq: outer-pass sequencer for the blitter (parameter read, inner loop, pass count).
// Define BLIT_SUSPEND_EN to add the HOLD input, which stalls the machine in NEXT.
module blit_outer_seq (
    input  logic       CCLK,
    input  logic       SRESET,
    input  logic       START,
    input  logic       PARRD,
    input  logic [7:0] OCNTLD,
    input  logic       PARDN,
    input  logic       INNDN,
`ifdef BLIT_SUSPEND_EN
    input  logic       HOLD,
`endif
    output logic       RDPAR,
    output logic       INNGO,
    output logic       BUSY,
    output logic       ODONE,
    output logic [7:0] OCNT
);
    typedef enum logic [2:0] {IDLE, PARAM, INNER, NEXT, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] ocnt_q, ocnt_d;
    logic       rdpar_q, inngo_q, busy_q, odone_q;
    logic       hold;
`ifdef BLIT_SUSPEND_EN
    assign hold = HOLD;
`else
    assign hold = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        ocnt_d  = ocnt_q;
        case (state_q)
            IDLE: if (START) begin
                state_d = PARRD ? PARAM : INNER;
                ocnt_d  = OCNTLD;
            end
            PARAM: if (PARDN) state_d = INNER;
            INNER: if (INNDN) state_d = NEXT;
            // a count of 1 means this was the last pass; 0 wraps to 255 for 256 passes
            NEXT: if (!hold) begin
                ocnt_d  = ocnt_q - 8'd1;
                state_d = (ocnt_q == 8'd1) ? DONE : (PARRD ? PARAM : INNER);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge CCLK) begin
        if (SRESET) begin
            state_q <= IDLE;
            ocnt_q  <= 8'd0;
            rdpar_q <= 1'b0;
            inngo_q <= 1'b0;
            busy_q  <= 1'b0;
            odone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ocnt_q  <= ocnt_d;
            rdpar_q <= state_d == PARAM;
            inngo_q <= state_d == INNER && state_q != INNER;
            busy_q  <= state_d != IDLE;
            odone_q <= state_d == DONE;
        end
    end
    assign RDPAR = rdpar_q;
    assign INNGO = inngo_q;
    assign BUSY  = busy_q;
    assign ODONE = odone_q;
    assign OCNT  = ocnt_q;
endmodule

// File: tb/tb_blit_outer_seq.sv
// tb_blit_outer_seq: randomized command-level checks of blit_outer_seq against expected pass/event sequence.
module tb_blit_outer_seq;
    logic       CCLK, SRESET, START, PARRD, PARDN, INNDN;
    logic [7:0] OCNTLD;
    logic       RDPAR, INNGO, BUSY, ODONE;
    logic [7:0] OCNT;
`ifdef BLIT_SUSPEND_EN
    logic       HOLD;
`endif
    int n_checks = 0;
    int n_pass = 0;

    blit_outer_seq dut (
        .CCLK(CCLK), .SRESET(SRESET), .START(START), .PARRD(PARRD), .OCNTLD(OCNTLD),
        .PARDN(PARDN), .INNDN(INNDN),
`ifdef BLIT_SUSPEND_EN
        .HOLD(HOLD),
`endif
        .RDPAR(RDPAR), .INNGO(INNGO), .BUSY(BUSY), .ODONE(ODONE), .OCNT(OCNT)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic step();
        @(negedge CCLK);
    endtask

    task automatic check_idle(input string tag);
        check(tag, {RDPAR, INNGO, BUSY, ODONE, OCNT}, 32'd0);
    endtask

    // One command: a pass is (optional parameter read) + inner loop; n passes, then one ODONE.
    task automatic run_cmd(input int load, input bit parrd, input int pd_dly, input int in_dly,
                           input int hold_pass, input int hold_len, input int abort_pass, input bit noise);
        int n;
        logic [7:0] rem;
        n   = (load == 0) ? 256 : load;
        rem = load[7:0];
        START = 1'b1; OCNTLD = load[7:0]; PARRD = parrd; PARDN = noise & parrd;
        step();
        START = 1'b0; PARDN = 1'b0; OCNTLD = 8'($urandom);
        check("busy_start", BUSY, 1'b1);
        check("ocnt_load", OCNT, rem);
        for (int p = 0; p < n; p++) begin
            if (parrd) begin
                check("rdpar_rise", RDPAR, 1'b1);
                check("inngo_in_param", INNGO, 1'b0);
                if (p == abort_pass) begin
                    SRESET = 1'b1;
                    step();
                    SRESET = 1'b0;
                    check_idle("abort_outputs");
                    repeat (3) begin
                        step();
                        check_idle("abort_quiet");
                    end
                    return;
                end
                repeat (pd_dly) begin
                    INNDN = noise & 1'($urandom);
                    START = noise & 1'($urandom);
                    step();
                    check("rdpar_hold", RDPAR, 1'b1);
                end
                INNDN = 1'b0; START = 1'b0; PARDN = 1'b1;
                step();
                PARDN = 1'b0;
            end
            check("rdpar_low_inner", RDPAR, 1'b0);
            check("inngo_rise", INNGO, 1'b1);
            check("ocnt_pass", OCNT, rem);
            repeat (in_dly) begin
                PARDN = noise & 1'($urandom);
                START = noise & 1'($urandom);
`ifdef BLIT_SUSPEND_EN
                HOLD = noise & 1'($urandom);
`endif
                step();
                check("inngo_pulse", INNGO, 1'b0);
            end
            PARDN = 1'b0; START = 1'b0; INNDN = 1'b1;
`ifdef BLIT_SUSPEND_EN
            HOLD = 1'b0;
`endif
            step();
            INNDN = 1'b0;
            check("next_quiet", {BUSY, RDPAR, INNGO, ODONE}, 4'b1000);
`ifdef BLIT_SUSPEND_EN
            if (p == hold_pass) begin
                HOLD = 1'b1;
                repeat (hold_len) begin
                    step();
                    check("hold_ocnt", OCNT, rem);
                    check("hold_quiet", {BUSY, RDPAR, INNGO, ODONE}, 4'b1000);
                end
                HOLD = 1'b0;
            end
`endif
            rem = rem - 8'd1;
            PARDN = noise & parrd;
            step();
            PARDN = 1'b0;
            check("ocnt_dec", OCNT, rem);
            if (p == n - 1) begin
                check("odone_hi", {ODONE, BUSY, RDPAR, INNGO}, 4'b1100);
                step();
                check("odone_lo", ODONE, 1'b0);
                check("busy_lo", BUSY, 1'b0);
            end
        end
    endtask

    initial begin
        SRESET = 1'b1; START = 1'b0; PARRD = 1'b0; PARDN = 1'b0; INNDN = 1'b0; OCNTLD = 8'd0;
`ifdef BLIT_SUSPEND_EN
        HOLD = 1'b0;
`endif
        step(); step();
        SRESET = 1'b0;
        check_idle("reset");
        repeat (4) begin
            PARDN = 1'($urandom); INNDN = 1'($urandom);
            step();
            check_idle("idle_noise");
        end
        PARDN = 1'b0; INNDN = 1'b0;
        run_cmd(3, 1'b1, 4, 5, -1, 0, -1, 1'b0);
        run_cmd(2, 1'b0, 1, 3, -1, 0, -1, 1'b0);
        run_cmd(0, 1'b0, 1, 1, -1, 0, -1, 1'b0);
        run_cmd(3, 1'b1, 2, 2, -1, 0, 1, 1'b0);
        run_cmd(2, 1'b1, 2, 2, 0, 10, -1, 1'b0);
        for (int i = 0; i < 25; i++) begin
            run_cmd($urandom_range(1, 6), 1'($urandom), $urandom_range(1, 4), $urandom_range(1, 5),
                    $urandom_range(0, 3), $urandom_range(1, 5),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                PARDN = 1'($urandom); INNDN = 1'($urandom);
                step();
                check_idle("idle_gap");
            end
            PARDN = 1'b0; INNDN = 1'b0;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
